score_stepper: RTL and testbench

Drives a two-digit BCD score display built from chained decimal digit counters (units and tens, each with edge-triggered inc/dec inputs). Accepts a requested target score 00–99 and emits correctly spaced inc/dec pulse trains until the digit counters reach it. Propagates units wrap directly to the tens digit and keeps an internal mirror of the displayed value. Sits between game logic (scoring events, new-game clear) and the digit counters.

---
 rtl/score_stepper.sv | 180 ++++++++++++++++++
 tb/tb_score_stepper.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_stepper.sv
// score_stepper: walks a pair of chained BCD digit counters (units, tens)
// from the currently displayed score to a requested target by emitting
// spaced inc/dec pulse trains, while mirroring the displayed value.
module score_stepper #(
    parameter int unsigned PULSE_LEN = 1,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] target_tens,
    input  logic [3:0] target_units,
    input  logic       clear,
    output logic       inc_units,
    output logic       dec_units,
    output logic       inc_tens,
    output logic       dec_tens,
    output logic       digits_reset,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] cur_tens,
    output logic [3:0] cur_units
);

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] tgt_tens;
    logic [3:0] tgt_units;
    logic [3:0] cnt;
    logic       dir_up;

    logic       req_bad;
    logic [6:0] req_val;
    logic [6:0] cur_val;
    logic       at_target;
    logic [3:0] nxt_tens;
    logic [3:0] nxt_units;

    // Request validation, binary comparison values and the one-step BCD
    // successor/predecessor of the mirror in the current direction.
    always_comb begin
        req_bad   = (target_tens > 4'd9) || (target_units > 4'd9);
        req_val   = 7'(target_tens) * 7'd10 + 7'(target_units);
        cur_val   = 7'(cur_tens) * 7'd10 + 7'(cur_units);
        at_target = (cur_tens == tgt_tens) && (cur_units == tgt_units);
        nxt_tens  = cur_tens;
        nxt_units = cur_units;
        if (dir_up) begin
            if (cur_units == 4'd9) begin
                nxt_units = 4'd0;
                nxt_tens  = (cur_tens == 4'd9) ? 4'd0 : cur_tens + 4'd1;
            end else begin
                nxt_units = cur_units + 4'd1;
            end
        end else begin
            if (cur_units == 4'd0) begin
                nxt_units = 4'd9;
                nxt_tens  = (cur_tens == 4'd0) ? 4'd9 : cur_tens - 4'd1;
            end else begin
                nxt_units = cur_units - 4'd1;
            end
        end
    end

    // Control FSM; every output is a register so the counters see clean pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tgt_tens     <= 4'd0;
            tgt_units    <= 4'd0;
            cnt          <= 4'd0;
            dir_up       <= 1'b0;
            inc_units    <= 1'b0;
            dec_units    <= 1'b0;
            inc_tens     <= 1'b0;
            dec_tens     <= 1'b0;
            digits_reset <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cur_tens     <= 4'd0;
            cur_units    <= 4'd0;
        end else if (clear) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            inc_units    <= 1'b0;
            dec_units    <= 1'b0;
            inc_tens     <= 1'b0;
            dec_tens     <= 1'b0;
            digits_reset <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cur_tens     <= 4'd0;
            cur_units    <= 4'd0;
        end else begin
            digits_reset <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_bad) begin
                            err <= 1'b1;
                        end else begin
                            tgt_tens  <= target_tens;
                            tgt_units <= target_units;
                            cnt       <= 4'd0;
                            if (req_val > cur_val) begin
                                dir_up    <= 1'b1;
                                state     <= PULSE;
                                busy      <= 1'b1;
                                inc_units <= 1'b1;
                                inc_tens  <= (cur_units == 4'd9);
                            end else if (req_val < cur_val) begin
                                dir_up    <= 1'b0;
                                state     <= PULSE;
                                busy      <= 1'b1;
                                dec_units <= 1'b1;
                                dec_tens  <= (cur_units == 4'd0);
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        cnt       <= 4'd0;
                        state     <= GAP;
                        inc_units <= 1'b0;
                        dec_units <= 1'b0;
                        inc_tens  <= 1'b0;
                        dec_tens  <= 1'b0;
                        cur_tens  <= nxt_tens;
                        cur_units <= nxt_units;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= 4'd0;
                        if (at_target) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= PULSE;
                            inc_units <= dir_up;
                            dec_units <= !dir_up;
                            inc_tens  <= dir_up && (cur_units == 4'd9);
                            dec_tens  <= !dir_up && (cur_units == 4'd0);
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_stepper.sv
// Testbench for score_stepper: two instances (default timing and 3/2 timing)
// driven by directed steps; expected output vectors per cycle are queued when
// stimulus is applied and compared when that cycle's outputs are sampled.
module tb_score_stepper;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Generate the free-running clock.
    always #5 clk = ~clk;

    logic       a_start = 1'b0, a_clear = 1'b0;
    logic [3:0] a_tt = 4'd0, a_tu = 4'd0;
    logic       a_inc_units, a_dec_units, a_inc_tens, a_dec_tens;
    logic       a_digits_reset, a_busy, a_done, a_err;
    logic [3:0] a_cur_tens, a_cur_units;

    logic       b_start = 1'b0, b_clear = 1'b0;
    logic [3:0] b_tt = 4'd0, b_tu = 4'd0;
    logic       b_inc_units, b_dec_units, b_inc_tens, b_dec_tens;
    logic       b_digits_reset, b_busy, b_done, b_err;
    logic [3:0] b_cur_tens, b_cur_units;

    score_stepper dut_a (
        .clk(clk), .reset(reset), .start(a_start),
        .target_tens(a_tt), .target_units(a_tu), .clear(a_clear),
        .inc_units(a_inc_units), .dec_units(a_dec_units),
        .inc_tens(a_inc_tens), .dec_tens(a_dec_tens),
        .digits_reset(a_digits_reset), .busy(a_busy), .done(a_done), .err(a_err),
        .cur_tens(a_cur_tens), .cur_units(a_cur_units)
    );

    score_stepper #(.PULSE_LEN(3), .GAP_LEN(2)) dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .target_tens(b_tt), .target_units(b_tu), .clear(b_clear),
        .inc_units(b_inc_units), .dec_units(b_dec_units),
        .inc_tens(b_inc_tens), .dec_tens(b_dec_tens),
        .digits_reset(b_digits_reset), .busy(b_busy), .done(b_done), .err(b_err),
        .cur_tens(b_cur_tens), .cur_units(b_cur_units)
    );

    logic [15:0] a_vec, b_vec;
    assign a_vec = {a_inc_units, a_dec_units, a_inc_tens, a_dec_tens,
                    a_digits_reset, a_busy, a_done, a_err, a_cur_tens, a_cur_units};
    assign b_vec = {b_inc_units, b_dec_units, b_inc_tens, b_dec_tens,
                    b_digits_reset, b_busy, b_done, b_err, b_cur_tens, b_cur_units};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          qa_c[$];
    logic [15:0] qa_e[$];
    string       qa_t[$];
    int          qb_c[$];
    logic [15:0] qb_e[$];
    string       qb_t[$];

    // Count rising edges so stimulus and checks share one cycle index.
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [15:0] mk(bit iu, bit du, bit it, bit dt, bit dr,
                                       bit bz, bit dn, bit er, int v);
        return {iu, du, it, dt, dr, bz, dn, er, 4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic push(int d, int c, logic [15:0] e, string t);
        if (d == 0) begin
            qa_c.push_back(c); qa_e.push_back(e); qa_t.push_back(t);
        end else begin
            qb_c.push_back(c); qb_e.push_back(e); qb_t.push_back(t);
        end
    endtask

    task automatic check_output(string tag, int exp_c, int obs_c,
                                logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp && obs_c == exp_c) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d (sampled %0d): observed %h required %h",
                   tag, exp_c, obs_c, obs, exp);
        end
    endtask

    // Expected trace of a move started at cycle t, pushed for cycles <= stop.
    task automatic gen_move(int d, int from, int to, int p, int g, int t,
                            int stop, output int last);
        int  n;
        int  v;
        int  c;
        bit  up;
        up = (to > from);
        n  = up ? to - from : from - to;
        v  = from;
        c  = t + 1;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                if (c <= stop)
                    push(d, c, mk(up, !up, up && (v % 10 == 9), !up && (v % 10 == 0),
                                  0, 1, 0, 0, v), "pulse");
                c++;
            end
            v = up ? v + 1 : v - 1;
            for (int i = 0; i < g; i++) begin
                if (c <= stop) push(d, c, mk(0, 0, 0, 0, 0, 1, 0, 0, v), "gap");
                c++;
            end
        end
        if (c <= stop) push(d, c, mk(0, 0, 0, 0, 0, 0, 1, 0, to), "done");
        c++;
        if (c <= stop) push(d, c, mk(0, 0, 0, 0, 0, 0, 0, 0, to), "after_done");
        last = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    // Drive a one-cycle request on the selected instance.
    task automatic apply_stimulus(int d, bit s, logic [3:0] tt, logic [3:0] tu, bit cl);
        if (d == 0) begin
            a_start = s; a_tt = tt; a_tu = tu; a_clear = cl;
        end else begin
            b_start = s; b_tt = tt; b_tu = tu; b_clear = cl;
        end
        tick();
        if (d == 0) begin
            a_start = 1'b0; a_clear = 1'b0;
        end else begin
            b_start = 1'b0; b_clear = 1'b0;
        end
    endtask

    // Compare every queued expectation whose cycle has arrived.
    always @(negedge clk) begin
        int          c;
        logic [15:0] e;
        string       t;
        while (qa_c.size() > 0 && qa_c[0] <= cyc) begin
            c = qa_c.pop_front(); e = qa_e.pop_front(); t = qa_t.pop_front();
            check_output({"A.", t}, c, cyc, a_vec, e);
        end
        while (qb_c.size() > 0 && qb_c[0] <= cyc) begin
            c = qb_c.pop_front(); e = qb_e.pop_front(); t = qb_t.pop_front();
            check_output({"B.", t}, c, cyc, b_vec, e);
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int t;
        int last;
        int stop;

        $display("[TB] starting score_stepper bench");
        tick();
        tick();
        push(0, cyc, 16'h0000, "reset");
        push(1, cyc, 16'h0000, "reset");
        reset = 1'b0;
        tick();
        push(0, cyc, 16'h0000, "post_reset");
        push(1, cyc, 16'h0000, "post_reset");

        // 00 -> 03, then 03 -> 08, 08 -> 12 (tens carry), 12 -> 12, 12 -> 09.
        t = cyc; gen_move(0, 0, 3, 1, 1, t, 100000, last);
        apply_stimulus(0, 1, 4'd0, 4'd3, 0); wait_until(last);
        t = cyc; gen_move(0, 3, 8, 1, 1, t, 100000, last);
        apply_stimulus(0, 1, 4'd0, 4'd8, 0); wait_until(last);
        t = cyc; gen_move(0, 8, 12, 1, 1, t, 100000, last);
        apply_stimulus(0, 1, 4'd1, 4'd2, 0); wait_until(last);
        t = cyc; gen_move(0, 12, 12, 1, 1, t, 100000, last);
        apply_stimulus(0, 1, 4'd1, 4'd2, 0); wait_until(last);
        t = cyc; gen_move(0, 12, 9, 1, 1, t, 100000, last);
        apply_stimulus(0, 1, 4'd0, 4'd9, 0); wait_until(last);

        // Invalid units digit.
        t = cyc;
        push(0, t + 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 9), "err");
        push(0, t + 2, mk(0, 0, 0, 0, 0, 0, 0, 0, 9), "after_err");
        apply_stimulus(0, 1, 4'd0, 4'd10, 0); wait_until(t + 2);

        // Clear from idle.
        t = cyc;
        push(0, t + 1, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "clear_idle");
        push(0, t + 2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "after_clear");
        apply_stimulus(0, 0, 4'd0, 4'd0, 1); wait_until(t + 2);

        // 00 -> 50, cleared at the start of step 20.
        t = cyc; stop = t + 41;
        gen_move(0, 0, 50, 1, 1, t, stop, last);
        apply_stimulus(0, 1, 4'd5, 4'd0, 0); wait_until(stop);
        push(0, stop + 1, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "clear_mid");
        push(0, stop + 2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "after_clear_mid");
        apply_stimulus(0, 0, 4'd0, 4'd0, 1); wait_until(stop + 2);

        // Start and clear together: clear only; a start the next cycle is taken.
        t = cyc;
        push(0, t + 1, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "clear_start");
        apply_stimulus(0, 1, 4'd0, 4'd5, 1);
        t = cyc; gen_move(0, 0, 1, 1, 1, t, 100000, last);
        apply_stimulus(0, 1, 4'd0, 4'd1, 0); wait_until(last);

        // Stretched timing, 00 -> 02, with a start while busy that must be ignored.
        t = cyc; gen_move(1, 0, 2, 3, 2, t, 100000, last);
        apply_stimulus(1, 1, 4'd0, 4'd2, 0);
        wait_until(t + 4);
        apply_stimulus(1, 1, 4'd0, 4'd7, 0);
        wait_until(last);

        // Invalid tens digit on the stretched instance.
        t = cyc;
        push(1, t + 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 2), "err_tens");
        push(1, t + 2, mk(0, 0, 0, 0, 0, 0, 0, 0, 2), "after_err_tens");
        apply_stimulus(1, 1, 4'd12, 4'd0, 0);
        wait_until(t + 3);
        tick();

        checks++;
        assert (qa_c.size() + qb_c.size() == 0) else begin
            errors++;
            $error("[TB] FAIL queue_drain: observed %0d pending required 0",
                   qa_c.size() + qb_c.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
